// File: rtl/clock_divider_prog.sv
// rtl/clock_divider_prog.sv - multi-channel programmable clock divider with duty-cycle control
// Period/high-time are double-buffered; shadow values go live at wrap, sync or while disabled.
module clock_divider_prog #(
   parameter int CHANNELS       = 4,
   parameter int DIV_WIDTH      = 16,
   parameter int DEFAULT_PERIOD = 1000,
   parameter int CH_BITS        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [CHANNELS-1:0]  i_ch_enable,
   input  logic                 i_sync,
   input  logic                 i_wr_en,
   input  logic [CH_BITS-1:0]   i_wr_ch,
   input  logic [DIV_WIDTH-1:0] i_wr_period,
   input  logic [DIV_WIDTH-1:0] i_wr_high,
   output logic [CHANNELS-1:0]  o_clk,
   output logic [CHANNELS-1:0]  o_tick,
   output logic                 o_wr_err
);

   localparam logic [DIV_WIDTH-1:0] RST_P = DIV_WIDTH'(DEFAULT_PERIOD);
   localparam logic [DIV_WIDTH-1:0] RST_H = DIV_WIDTH'(DEFAULT_PERIOD / 2);

   logic wr_valid;
   logic wr_err_q;

   assign wr_valid = i_wr_en && (32'(i_wr_ch) < 32'(CHANNELS)) && (i_wr_period >= DIV_WIDTH'(2));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_err_q <= 1'b0;
      end else begin
         wr_err_q <= i_wr_en && !wr_valid;
      end
   end

   assign o_wr_err = wr_err_q;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
      logic [DIV_WIDTH-1:0] pa_q, pa_d, ha_q, ha_d;
      logic [DIV_WIDTH-1:0] ps_q, ps_d, hs_q, hs_d;
      logic                 pend_q, pend_d;
      logic                 en_q, en_d;
      logic                 clk_q, clk_d;
      logic                 tick_q, tick_d;
      logic                 wr_hit;
      logic                 wrap;
      logic                 restart;
      logic                 apply;

      assign wr_hit  = wr_valid && (i_wr_ch == CH_BITS'(c));
      assign wrap    = (cnt_q == pa_q - DIV_WIDTH'(1));
      assign restart = i_ch_enable[c] && (!en_q || i_sync);
      // Every edge of a disabled channel is an apply point, so writes land in one cycle.
      assign apply   = !i_ch_enable[c] || restart || wrap;

      always_comb begin
         ps_d   = ps_q;
         hs_d   = hs_q;
         pa_d   = pa_q;
         ha_d   = ha_q;
         pend_d = pend_q;
         if (wr_hit) begin
            ps_d = i_wr_period;
            hs_d = i_wr_high;
         end
         if (apply) begin
            pend_d = 1'b0;
            if (wr_hit) begin
               pa_d = i_wr_period;
               ha_d = i_wr_high;
            end else if (pend_q) begin
               pa_d = ps_q;
               ha_d = hs_q;
            end
         end else if (wr_hit) begin
            pend_d = 1'b1;
         end

         en_d   = i_ch_enable[c];
         cnt_d  = apply ? '0 : cnt_q + DIV_WIDTH'(1);
         clk_d  = i_ch_enable[c] && (cnt_d < ha_d);
         tick_d = i_ch_enable[c] && (cnt_d == '0);
      end

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            cnt_q  <= '0;
            pa_q   <= RST_P;
            ha_q   <= RST_H;
            ps_q   <= RST_P;
            hs_q   <= RST_H;
            pend_q <= 1'b0;
            en_q   <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            pa_q   <= pa_d;
            ha_q   <= ha_d;
            ps_q   <= ps_d;
            hs_q   <= hs_d;
            pend_q <= pend_d;
            en_q   <= en_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
         end
      end

      assign o_clk[c]  = clk_q;
      assign o_tick[c] = tick_q;
   end

endmodule

// File: tb/tb_clock_divider_prog.sv
// tb/tb_clock_divider_prog.sv - self-checking bench for clock_divider_prog
// Elapsed-time reference model compared every cycle, plus literal period/duty pins.
module tb_clock_divider_prog;

   localparam int CH = 3;
   localparam int DW = 16;
   localparam int DP = 10;
   localparam int CB = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sync = 1'b0;
   logic          wr_en = 1'b0;
   logic [CH-1:0] en = '0;
   logic [CB-1:0] wr_ch = '0;
   logic [DW-1:0] wr_p = '0;
   logic [DW-1:0] wr_h = '0;
   logic [CH-1:0] o_clk;
   logic [CH-1:0] o_tick;
   logic          o_err;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   clock_divider_prog #(
      .CHANNELS(CH),
      .DIV_WIDTH(DW),
      .DEFAULT_PERIOD(DP)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_ch_enable(en),
      .i_sync(sync),
      .i_wr_en(wr_en),
      .i_wr_ch(wr_ch),
      .i_wr_period(wr_p),
      .i_wr_high(wr_h),
      .o_clk(o_clk),
      .o_tick(o_tick),
      .o_wr_err(o_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: each running channel remembers when its current period began.
   int            t = 0;
   bit            mvalid = 1'b0;
   bit            mrun [CH];
   int            mstart [CH];
   int            mp [CH];
   int            mh [CH];
   int            sp [CH];
   int            sh [CH];
   bit            mpend [CH];
   logic [CH-1:0] e_clk = '0;
   logic [CH-1:0] e_tick = '0;
   logic          e_err = 1'b0;

   always @(posedge clk) begin
      bit hit;
      bit ap;
      t++;
      if (rst) begin
         mvalid = 1'b1;
         e_err  = 1'b0;
         for (int c = 0; c < CH; c++) begin
            mrun[c] = 1'b0;
            mp[c] = DP;
            mh[c] = DP / 2;
            sp[c] = DP;
            sh[c] = DP / 2;
            mpend[c] = 1'b0;
            e_clk[c] = 1'b0;
            e_tick[c] = 1'b0;
         end
      end else begin
         e_err = wr_en && (int'(wr_ch) >= CH || int'(wr_p) < 2);
         for (int c = 0; c < CH; c++) begin
            hit = wr_en && int'(wr_ch) == c && int'(wr_p) >= 2;
            ap = 1'b0;
            if (!en[c]) begin
               mrun[c] = 1'b0;
               ap = 1'b1;
            end else if (!mrun[c] || sync) begin
               mrun[c] = 1'b1;
               ap = 1'b1;
               mstart[c] = t;
            end else if (t - mstart[c] == mp[c]) begin
               ap = 1'b1;
               mstart[c] = t;
            end
            if (ap) begin
               if (hit) begin
                  mp[c] = int'(wr_p);
                  mh[c] = int'(wr_h);
               end else if (mpend[c]) begin
                  mp[c] = sp[c];
                  mh[c] = sh[c];
               end
               mpend[c] = 1'b0;
            end else if (hit) begin
               sp[c] = int'(wr_p);
               sh[c] = int'(wr_h);
               mpend[c] = 1'b1;
            end
            e_tick[c] = en[c] && (t - mstart[c] == 0);
            e_clk[c]  = en[c] && (t - mstart[c] < mh[c]);
         end
      end
   end

   // Per-cycle compare plus ch0 period/high-time observer.
   int ncyc = 0;
   int last0 = 0;
   int gap0 = 0;
   int hi0 = 0;
   int hicur0 = 0;

   always @(negedge clk) begin
      ncyc++;
      if (mvalid)
         check("model", {25'd0, o_clk, o_tick, o_err}, {25'd0, e_clk, e_tick, e_err});
      if (o_tick[0] === 1'b1) begin
         gap0 = ncyc - last0;
         last0 = ncyc;
         hi0 = hicur0;
         hicur0 = 0;
      end
      if (o_clk[0] === 1'b1) hicur0++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wr(input int ch, input int p, input int h);
      wr_en = 1'b1;
      wr_ch = CB'(ch);
      wr_p  = DW'(p);
      wr_h  = DW'(h);
      step(1);
      wr_en = 1'b0;
   endtask

   task automatic wait_tick0();
      int k = 0;
      do begin
         step(1);
         k++;
      end while (o_tick[0] !== 1'b1 && k < 60);
      if (o_tick[0] !== 1'b1) check("tick0_timeout", 32'(o_tick[0]), 32'd1);
   endtask

   task automatic pin_period(input string name, input int gap, input int hi);
      wait_tick0();
      check({name, "_gap"}, gap0, gap);
      check({name, "_hi"}, hi0, hi);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      step(2);
      check("rst_out", {25'd0, o_clk, o_tick, o_err}, 32'd0);
      rst = 1'b0;
      step(2);

      // Enable ch0 only: tick one cycle later, 10-cycle period, 5 high.
      en = 3'b001;
      step(1);
      check("en_first", {26'd0, o_clk, o_tick}, 32'b001_001);
      pin_period("default", 10, 5);
      check("ch12_idle", {28'd0, o_clk[2:1], o_tick[2:1]}, 32'd0);

      // Write P=7 H=2 at cnt=3: current period completes, then 7/2.
      step(3);
      wr(0, 7, 2);
      check("wr_ok_noerr", 32'(o_err), 32'd0);
      pin_period("switch_old", 10, 5);
      pin_period("switch_new", 7, 2);
      pin_period("switch_new2", 7, 2);

      // Rejected writes.
      wr(0, 1, 1);
      check("err_p1", 32'(o_err), 32'd1);
      step(1);
      check("err_clear", 32'(o_err), 32'd0);
      wr(3, 7, 2);
      check("err_ch3", 32'(o_err), 32'd1);
      wr(0, 0, 0);
      check("err_p0", 32'(o_err), 32'd1);
      pin_period("after_rej", 7, 2);

      // Duty boundaries H=0 and H>=P.
      wr(0, 10, 0);
      pin_period("h0_old", 7, 2);
      pin_period("h0", 10, 0);
      wr(0, 10, 12);
      pin_period("h12_old", 10, 0);
      pin_period("h12", 10, 10);

      // ch1 written while disabled, enabled skewed, then sync.
      wr(1, 4, 2);
      en = 3'b011;
      step(3);
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      check("sync_tick", {30'd0, o_tick[1:0]}, 32'b11);
      step(10);
      check("sync_10", {30'd0, o_tick[1:0]}, 32'b01);
      step(10);
      check("sync_20", {30'd0, o_tick[1:0]}, 32'b11);

      // Reset with a pending write discards it.
      wr(0, 5, 1);
      step(2);
      rst = 1'b1;
      step(1);
      check("rst_mid", {25'd0, o_clk, o_tick, o_err}, 32'd0);
      en = 3'b001;
      rst = 1'b0;
      wait_tick0();
      pin_period("post_rst", 10, 5);
      pin_period("post_rst2", 10, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
